// File: rtl/cla_adder_pipe.sv
// Pipelined carry-lookahead adder/subtractor; stage k resolves its slice of GROUP-bit lookahead groups.
// Latency STAGES cycles from acceptance to out_valid; throughput one result per cycle.
// Backpressure: one global enable (!out_valid | out_ready) freezes every stage; in_ready mirrors it.
module cla_adder_pipe #(
    parameter int WIDTH  = 16,
    parameter int GROUP  = 4,
    parameter int STAGES = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf
);

    localparam int NGRP = WIDTH / GROUP;   // lookahead groups across the word
    localparam int GPS  = NGRP / STAGES;   // groups resolved per stage
    localparam int SW   = GPS * GROUP;     // bits resolved per stage

    // Bit-level lookahead inside one group: every carry is a flat
    // sum-of-products of g/p and the group carry-in, never a ripple.
    function automatic logic [GROUP:0] grp_carry(input logic [GROUP-1:0] g,
                                                 input logic [GROUP-1:0] p,
                                                 input logic             ci);
        logic [GROUP:0] c;
        logic           term;
        c    = '0;
        c[0] = ci;
        for (int j = 1; j <= GROUP; j++) begin
            c[j] = ci;
            for (int i = 0; i < j; i++) c[j] = c[j] & p[i];
            for (int i = 0; i < j; i++) begin
                term = g[i];
                for (int m = i + 1; m < j; m++) term = term & p[m];
                c[j] = c[j] | term;
            end
        end
        return c;
    endfunction

    // Group-level lookahead over the groups owned by one stage.
    function automatic logic [GPS:0] stg_carry(input logic [GPS-1:0] g,
                                               input logic [GPS-1:0] p,
                                               input logic           ci);
        logic [GPS:0] c;
        logic         term;
        c    = '0;
        c[0] = ci;
        for (int j = 1; j <= GPS; j++) begin
            c[j] = ci;
            for (int i = 0; i < j; i++) c[j] = c[j] & p[i];
            for (int i = 0; i < j; i++) begin
                term = g[i];
                for (int m = i + 1; m < j; m++) term = term & p[m];
                c[j] = c[j] | term;
            end
        end
        return c;
    endfunction

    // Resolve one stage slice: returns {carry_out, sum[SW-1:0]}.
    function automatic logic [SW:0] stage_resolve(input logic [SW-1:0] x,
                                                  input logic [SW-1:0] y,
                                                  input logic          ci);
        logic [SW-1:0]  bg, bp, sum;
        logic [GPS-1:0] gg, gp;
        logic [GPS:0]   gc;
        logic [GROUP:0] bc;
        bg  = x & y;
        bp  = x ^ y;
        sum = '0;
        gg  = '0;
        gp  = '0;
        for (int i = 0; i < GPS; i++) begin
            bc    = grp_carry(bg[i*GROUP +: GROUP], bp[i*GROUP +: GROUP], 1'b0);
            gg[i] = bc[GROUP];
            gp[i] = &bp[i*GROUP +: GROUP];
        end
        gc = stg_carry(gg, gp, ci);
        for (int i = 0; i < GPS; i++) begin
            bc = grp_carry(bg[i*GROUP +: GROUP], bp[i*GROUP +: GROUP], gc[i]);
            sum[i*GROUP +: GROUP] = bp[i*GROUP +: GROUP] ^ bc[GROUP-1:0];
        end
        return {gc[GPS], sum};
    endfunction

    logic             en;
    logic [WIDTH-1:0] beff;
    logic             c0;

    // Subtract is a + ~b + 1, so cin is replaced by a forced carry-in.
    assign beff     = sub ? ~b : b;
    assign c0       = sub | cin;
    assign en       = !out_valid | out_ready;
    assign in_ready = en;

    for (genvar k = 0; k < STAGES; k++) begin : stg
        localparam int LO      = k * SW;        // first bit resolved here
        localparam int HI_NEXT = (k + 1) * SW;  // first bit left for later stages

        logic [WIDTH-1:LO]  a_in, b_in;         // still-unresolved operand bits
        logic               c_in, am_in, bm_in, v_in;
        logic [HI_NEXT-1:0] sum_acc;            // all sum bits known after this stage
        logic [SW:0]        res;

        assign res = stage_resolve(a_in[LO+SW-1:LO], b_in[LO+SW-1:LO], c_in);

        if (k == 0) begin : g_src
            assign a_in    = a;
            assign b_in    = beff;
            assign c_in    = c0;
            assign am_in   = a[WIDTH-1];
            assign bm_in   = beff[WIDTH-1];
            assign v_in    = in_valid;
            assign sum_acc = res[SW-1:0];
        end else begin : g_src
            assign a_in    = stg[k-1].g_reg.a_q;
            assign b_in    = stg[k-1].g_reg.b_q;
            assign c_in    = stg[k-1].g_reg.c_q;
            assign am_in   = stg[k-1].g_reg.am_q;
            assign bm_in   = stg[k-1].g_reg.bm_q;
            assign v_in    = stg[k-1].g_reg.v_q;
            assign sum_acc = {res[SW-1:0], stg[k-1].g_reg.sum_q};
        end

        if (k < STAGES - 1) begin : g_reg
            logic [WIDTH-1:HI_NEXT] a_q, b_q;
            logic [HI_NEXT-1:0]     sum_q;
            logic                   c_q, am_q, bm_q, v_q;

            // Inter-stage register: resolved low sum, pending upper operands, boundary carry.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    a_q   <= '0;
                    b_q   <= '0;
                    sum_q <= '0;
                    c_q   <= 1'b0;
                    am_q  <= 1'b0;
                    bm_q  <= 1'b0;
                    v_q   <= 1'b0;
                end else if (en) begin
                    a_q   <= a_in[WIDTH-1:HI_NEXT];
                    b_q   <= b_in[WIDTH-1:HI_NEXT];
                    sum_q <= sum_acc;
                    c_q   <= res[SW];
                    am_q  <= am_in;
                    bm_q  <= bm_in;
                    v_q   <= v_in;
                end
            end
        end else begin : g_out
            // Output register: full result plus signed overflow from the operand MSBs.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    out_valid <= 1'b0;
                    s         <= '0;
                    cout      <= 1'b0;
                    ovf       <= 1'b0;
                end else if (en) begin
                    out_valid <= v_in;
                    s         <= sum_acc;
                    cout      <= res[SW];
                    ovf       <= (am_in == bm_in) & (sum_acc[WIDTH-1] != am_in);
                end
            end
        end
    end

endmodule

// File: tb/tb_cla_adder_pipe.sv
// Bench for cla_adder_pipe: directed literals, backpressure, mid-stream reset, random streams.
// Reference: arithmetic model of the result plus a STAGES-deep expected-result pipe honouring the global enable.
// Compares in_ready/out_valid every cycle and s/cout/ovf whenever a result is valid.
module tb_cla_adder_pipe;

    localparam int W      = 16;
    localparam int STAGES = 2;
    localparam int L      = STAGES - 1;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         o;
    } exp_t;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;

    int n_cmp  = 0;
    int n_fail = 0;
    bit armed  = 1'b0;

    exp_t mdat [STAGES];
    logic mvld [STAGES];

    cla_adder_pipe #(.WIDTH(W), .GROUP(4), .STAGES(STAGES)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .a(a), .b(b), .cin(cin), .sub(sub),
        .out_valid(out_valid), .out_ready(out_ready),
        .s(s), .cout(cout), .ovf(ovf)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // Result from plain integer arithmetic; overflow as an out-of-range signed result.
    function automatic exp_t ref_result(input logic [W-1:0] x, input logic [W-1:0] y,
                                        input logic ci, input logic sb);
        exp_t   r;
        longint ux, uy, sx, sy, full, res, maxp, minn;
        ux   = longint'(x);
        uy   = longint'(y);
        sx   = longint'($signed(x));
        sy   = longint'($signed(y));
        maxp = (longint'(1) << (W - 1)) - 1;
        minn = -(longint'(1) << (W - 1));
        if (sb) begin
            full = ux - uy;
            r.s  = full[W-1:0];
            r.c  = (ux >= uy);
            res  = sx - sy;
        end else begin
            full = ux + uy + longint'(ci);
            r.s  = full[W-1:0];
            r.c  = full[W];
            res  = sx + sy + longint'(ci);
        end
        r.o = (res > maxp) || (res < minn);
        return r;
    endfunction

    function automatic logic [W-1:0] rand_operand();
        case ($urandom_range(7))
            0:       return '0;
            1:       return '1;
            2:       return {1'b0, {(W-1){1'b1}}};
            3:       return {1'b1, {(W-1){1'b0}}};
            default: return W'($urandom);
        endcase
    endfunction

    // Expected-result pipe: advances only when the spec's global enable is high.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < STAGES; i++) mvld[i] <= 1'b0;
        end else if (!mvld[L] || out_ready) begin
            for (int i = 1; i < STAGES; i++) begin
                mvld[i] <= mvld[i-1];
                mdat[i] <= mdat[i-1];
            end
            mvld[0] <= in_valid;
            mdat[0] <= ref_result(a, b, cin, sub);
        end
    end

    // Per-cycle compare, away from the rising edge.
    always @(negedge clk) begin
        if (armed) begin
            if (rst) begin
                check("rst_out_valid", out_valid, 0);
                check("rst_s", s, 0);
                check("rst_cout", cout, 0);
                check("rst_ovf", ovf, 0);
                check("rst_in_ready", in_ready, 1);
            end else begin
                check("in_ready", in_ready, (!mvld[L] || out_ready));
                check("out_valid", out_valid, mvld[L]);
                if (mvld[L]) begin
                    check("s", s, mdat[L].s);
                    check("cout", cout, mdat[L].c);
                    check("ovf", ovf, mdat[L].o);
                end
            end
        end
    end

    // One operation into an idle pipe; checks latency and literal result.
    task automatic directed(input string nm, input logic [W-1:0] ia, input logic [W-1:0] ib,
                            input logic ic, input logic isb,
                            input logic [W-1:0] es, input logic ec, input logic eo);
        int lat;
        a = ia; b = ib; cin = ic; sub = isb; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
        check({nm, "_latency"}, lat, STAGES);
        check({nm, "_valid"}, out_valid, 1);
        check({nm, "_s"}, s, es);
        check({nm, "_cout"}, cout, ec);
        check({nm, "_ovf"}, ovf, eo);
        @(posedge clk); #1;
    endtask

    task automatic run_stream(input int nops, input int vld_pct, input int rdy_pct);
        int   sent;
        int   cyc;
        logic acc;
        sent = 0;
        cyc  = 0;
        in_valid = 1'b0;
        while (sent < nops && cyc < nops * 20) begin
            if (!in_valid && (int'($urandom_range(99)) < vld_pct)) begin
                a = rand_operand();
                b = rand_operand();
                cin = 1'($urandom_range(1));
                sub = 1'($urandom_range(1));
                in_valid = 1'b1;
            end
            out_ready = (int'($urandom_range(99)) < rdy_pct);
            @(negedge clk);
            acc = in_valid & in_ready;
            @(posedge clk); #1;
            cyc++;
            if (acc) begin
                sent++;
                in_valid = 1'b0;
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (STAGES + 2) @(posedge clk);
        #1;
        check("stream_sent", sent, nops);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        n_fail++;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin : main
        exp_t         r;
        logic [W-1:0] bp_q [$];
        logic [W-1:0] got  [$];
        int           stall;
        bit           stalled;
        logic         acc;

        rst = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        #1 rst = 1'b1;
        armed = 1'b1;
        #1;
        check("reset_out_valid", out_valid, 0);
        check("reset_s", s, 0);
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        check("reset_in_ready", in_ready, 1);

        // Pin the reference model with hand-computed values.
        r = ref_result(16'hAA2A, 16'hCCCC, 1'b1, 1'b0);
        check("model_add", r, {16'h76F7, 1'b1, 1'b1});
        r = ref_result(16'h0005, 16'h0007, 1'b1, 1'b1);
        check("model_sub_neg", r, {16'hFFFE, 1'b0, 1'b0});
        r = ref_result(16'h0007, 16'h0005, 1'b0, 1'b1);
        check("model_sub_pos", r, {16'h0002, 1'b1, 1'b0});
        r = ref_result(16'h8000, 16'h0001, 1'b0, 1'b1);
        check("model_sub_ovf", r, {16'h7FFF, 1'b1, 1'b1});

        directed("add",      16'hAA2A, 16'hCCCC, 1'b1, 1'b0, 16'h76F7, 1'b1, 1'b1);
        directed("sub_5_7",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        directed("sub_7_5",  16'h0007, 16'h0005, 1'b1, 1'b1, 16'h0002, 1'b1, 1'b0);
        directed("carry_ch", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
        directed("ovf_pos",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

        // Backpressure: four back-to-back adds, out_ready dropped 3 cycles at first result.
        for (int k = 1; k <= 4; k++) bp_q.push_back(W'(k));
        cin = 1'b0; sub = 1'b0; out_ready = 1'b1;
        stall = 0; stalled = 1'b0;
        for (int cyc = 0; cyc < 40 && got.size() < 4; cyc++) begin
            if (!stalled && out_valid) begin
                stalled = 1'b1;
                stall = 3;
            end
            out_ready = (stall == 0);
            if (bp_q.size() > 0) begin
                in_valid = 1'b1; a = bp_q[0]; b = bp_q[0];
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            acc = in_valid && in_ready;
            if (stall > 0) begin
                check("bp_in_ready", in_ready, 0);
                check("bp_hold_s", s, W'(2));
                check("bp_hold_valid", out_valid, 1);
                stall--;
            end
            if (out_valid && out_ready) got.push_back(s);
            @(posedge clk); #1;
            if (acc) void'(bp_q.pop_front());
        end
        in_valid = 1'b0; out_ready = 1'b1;
        check("bp_count", got.size(), 4);
        for (int i = 0; i < got.size(); i++) check("bp_result", got[i], 2 * (i + 1));
        repeat (STAGES + 1) @(posedge clk);
        #1;

        // Reset with two operations in flight.
        in_valid = 1'b1; a = 16'd10; b = 16'd20; cin = 1'b0; sub = 1'b0;
        @(posedge clk); #1;
        a = 16'd30; b = 16'd40;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", out_valid, 0);
        check("rst_mid_s", s, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            check("rst_no_stale", out_valid, 0);
        end
        @(posedge clk); #1;
        directed("post_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, 16'h2345, 1'b0, 1'b0);

        run_stream(3000, 80, 70);
        run_stream(500, 100, 100);
        run_stream(500, 40, 30);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
